equiv_stim_ctrl: RTL and testbench

Sequencer for the equivalence-check harness. It generates a reproducible pseudo-random vector stream and drives it into both design instances (`top_1`, `top_2`) in parallel. It compares their 91-bit outputs after a fixed pipeline latency and reports the total mismatch count, the pass/fail result and the first failing vector index. It sits in the harness in place of free primary inputs, so that simulation and bounded runs exercise the same deterministic sequence.

---
 rtl/equiv_stim_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_equiv_stim_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/equiv_stim_ctrl.sv
// equiv_stim_ctrl: deterministic LFSR stimulus sequencer and dual-output comparator for the
// equivalence harness. Define EQUIV_FAIL_CAPTURE_EN to add first-failure capture ports.
module equiv_stim_ctrl #(
    parameter int          NUM_VECTORS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] SEED        = 64'hACE1_2468_9BDF_1357
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic signed [15:0] wire0,
    output logic [19:0]        wire1,
    output logic [2:0]         wire2,
    output logic [13:0]        wire3,
    input  logic [90:0]        y_1,
    input  logic [90:0]        y_2,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        mismatch_cnt,
    output logic [15:0]        fail_index
`ifdef EQUIV_FAIL_CAPTURE_EN
    ,
    output logic [90:0]        fail_y1,
    output logic [90:0]        fail_y2,
    output logic [52:0]        fail_vec
`endif
);

    localparam logic [63:0] LFSR_MASK  = 64'hD800_0000_0000_0000;
    localparam logic [15:0] NV16       = 16'(NUM_VECTORS);
    localparam int          LW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LW-1:0] DRAIN_LAST = LW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [63:0]     r_lfsr;
    logic [52:0]     r_vec;
    logic [15:0]     r_issue_cnt;
    logic [LW-1:0]   r_drain_cnt;
    logic [LATENCY-1:0] r_vld;
    logic [15:0]     r_idx [LATENCY];
    logic            w_busy;
    logic            w_done;
    logic            w_load;
    logic            w_issue;
    logic            w_miss;

`ifdef EQUIV_FAIL_CAPTURE_EN
    logic [52:0]     r_pvec [LATENCY];
    logic [90:0]     r_fail_y1;
    logic [90:0]     r_fail_y2;
    logic [52:0]     r_fail_vec;
`endif

    // One step of the right-shifting Galois LFSR for x^64+x^63+x^61+x^60+1.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        logic [63:0] shifted;
        shifted = {1'b0, s[63:1]};
        if (s[0]) begin
            lfsr_step = shifted ^ LFSR_MASK;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; RUN lingers one edge past the last issue so DRAIN spans LATENCY cycles
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next_state = S_RUN;
                else       w_next_state = r_state;
            end
            S_RUN: begin
                if (r_issue_cnt == NV16) w_next_state = S_DRAIN;
                else                     w_next_state = S_RUN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_next_state = S_DONE;
                else                           w_next_state = S_DRAIN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output and control decode from the registered state
    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_load  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE:  w_load = start;
            S_RUN: begin
                w_busy  = 1'b1;
                w_issue = (r_issue_cnt != NV16);
            end
            S_DRAIN: w_busy = 1'b1;
            S_DONE: begin
                w_done = 1'b1;
                w_load = start;
            end
            default: w_busy = 1'b0;
        endcase
        busy = w_busy;
        done = w_done;
        pass = w_done && (mismatch_cnt == 16'd0);
    end

    // r_lfsr always holds the state of the next vector to issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= 64'd0;
            r_vec       <= 53'd0;
            r_issue_cnt <= 16'd0;
        end else if (w_load) begin
            r_lfsr      <= lfsr_step(SEED);
            r_vec       <= SEED[52:0];
            r_issue_cnt <= 16'd1;
        end else if (w_issue) begin
            r_lfsr      <= lfsr_step(r_lfsr);
            r_vec       <= r_lfsr[52:0];
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + LW'(1);
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Valid/index pipeline aligning each issued vector with its y_* sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_idx[i] <= 16'd0;
`ifdef EQUIV_FAIL_CAPTURE_EN
                r_pvec[i] <= 53'd0;
`endif
            end
        end else begin
            r_vld[0] <= w_load | w_issue;
            r_idx[0] <= w_load ? 16'd0 : r_issue_cnt;
`ifdef EQUIV_FAIL_CAPTURE_EN
            r_pvec[0] <= w_load ? SEED[52:0] : r_lfsr[52:0];
`endif
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
`ifdef EQUIV_FAIL_CAPTURE_EN
                r_pvec[i] <= r_pvec[i-1];
`endif
            end
        end
    end

    assign w_miss = r_vld[LATENCY-1] && (y_1 != y_2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= 16'd0;
            fail_index   <= 16'hFFFF;
`ifdef EQUIV_FAIL_CAPTURE_EN
            r_fail_y1    <= 91'd0;
            r_fail_y2    <= 91'd0;
            r_fail_vec   <= 53'd0;
`endif
        end else if (w_load) begin
            mismatch_cnt <= 16'd0;
            fail_index   <= 16'hFFFF;
`ifdef EQUIV_FAIL_CAPTURE_EN
            r_fail_y1    <= 91'd0;
            r_fail_y2    <= 91'd0;
            r_fail_vec   <= 53'd0;
`endif
        end else if (w_miss) begin
            if (mismatch_cnt != 16'hFFFF) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
            if (fail_index == 16'hFFFF) begin
                fail_index <= r_idx[LATENCY-1];
`ifdef EQUIV_FAIL_CAPTURE_EN
                r_fail_y1  <= y_1;
                r_fail_y2  <= y_2;
                r_fail_vec <= r_pvec[LATENCY-1];
`endif
            end
        end
    end

    assign wire0 = $signed(r_vec[15:0]);
    assign wire1 = r_vec[35:16];
    assign wire2 = r_vec[38:36];
    assign wire3 = r_vec[52:39];

`ifdef EQUIV_FAIL_CAPTURE_EN
    assign fail_y1  = r_fail_y1;
    assign fail_y2  = r_fail_y2;
    assign fail_vec = r_fail_vec;
`endif

endmodule

// File: tb/tb_equiv_stim_ctrl.sv
// Self-checking bench for equiv_stim_ctrl: random y_* data and mismatch patterns against a
// reference built from the expected vector list and the compare-timing rules.
module tb_equiv_stim_ctrl;

    localparam int          N    = 16;
    localparam int          LAT  = 2;
    localparam logic [63:0] SEED = 64'hACE1_2468_9BDF_1357;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] wire0;
    logic [19:0]        wire1;
    logic [2:0]         wire2;
    logic [13:0]        wire3;
    logic [90:0]        y_1 = 91'd0;
    logic [90:0]        y_2 = 91'd0;
    logic               busy;
    logic               done;
    logic               pass;
    logic [15:0]        mismatch_cnt;
    logic [15:0]        fail_index;
`ifdef EQUIV_FAIL_CAPTURE_EN
    logic [90:0]        fail_y1;
    logic [90:0]        fail_y2;
    logic [52:0]        fail_vec;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [52:0] exp_vec [N];
    bit          inj [N];
    logic [90:0] flip_mask [N];

    equiv_stim_ctrl #(.NUM_VECTORS(N), .LATENCY(LAT), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3),
        .y_1(y_1), .y_2(y_2),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .fail_index(fail_index)
`ifdef EQUIV_FAIL_CAPTURE_EN
        , .fail_y1(fail_y1), .fail_y2(fail_y2), .fail_vec(fail_vec)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [90:0] rand91();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[90:0];
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_wires"}, 128'({wire3, wire2, wire1, wire0}), 128'd0);
        check_eq({tag, "_busy"}, 128'(busy), 128'd0);
        check_eq({tag, "_done"}, 128'(done), 128'd0);
        check_eq({tag, "_pass"}, 128'(pass), 128'd0);
        check_eq({tag, "_cnt"}, 128'(mismatch_cnt), 128'd0);
        check_eq({tag, "_fidx"}, 128'(fail_index), 128'hFFFF);
    endtask

    // Drives one run; mid_start_t / abort_t < 0 disable those events.
    task automatic do_run(input bit noise, input int mid_start_t, input int abort_t,
                          input bit chk_clear);
        int kn;
        int run_cnt;
        int run_first;
        int fin_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fin_cnt = 0;
        for (int k = 0; k < N; k++) if (inj[k]) fin_cnt++;
        for (int t = 0; t <= N + LAT; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (t == abort_t) begin
                rst = 1'b1;
                #1;
                check_reset_values("abort");
                @(posedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (chk_clear && t == 0) begin
                check_eq("restart_cnt", 128'(mismatch_cnt), 128'd0);
                check_eq("restart_fidx", 128'(fail_index), 128'hFFFF);
            end
            check_eq("vec", 128'({wire3, wire2, wire1, wire0}), 128'(exp_vec[(t < N) ? t : N-1]));
            check_eq("busy", 128'(busy), 128'(t < N + LAT));
            check_eq("done", 128'(done), 128'(t >= N + LAT));
            run_cnt = 0;
            run_first = 16'hFFFF;
            for (int k = 0; k < N && k <= t - LAT; k++) begin
                if (inj[k]) begin
                    if (run_cnt == 0) run_first = k;
                    run_cnt++;
                end
            end
            check_eq("cnt", 128'(mismatch_cnt), 128'(run_cnt));
            check_eq("fidx", 128'(fail_index), 128'(run_first));
            check_eq("pass", 128'(pass), 128'((t >= N + LAT) && (fin_cnt == 0)));
`ifdef EQUIV_FAIL_CAPTURE_EN
            if (t == N + LAT && run_cnt != 0) begin
                check_eq("cap_xor", 128'(fail_y1 ^ fail_y2), 128'(flip_mask[run_first]));
                check_eq("cap_vec", 128'(fail_vec), 128'(exp_vec[run_first]));
            end
`endif
            if (t == mid_start_t) start = 1'b1;
            kn = t + 1 - LAT;
            y_1 = rand91();
            if (kn >= 0 && kn < N) begin
                y_2 = inj[kn] ? (y_1 ^ flip_mask[kn]) : y_1;
            end else begin
                y_2 = noise ? ~y_1 : y_1;
            end
        end
    endtask

    initial begin
        logic [63:0] s;
        logic [90:0] m;
        s = SEED;
        for (int k = 0; k < N; k++) begin
            exp_vec[k] = s[52:0];
            if (s[0]) s = (s >> 1) ^ 64'hD800_0000_0000_0000;
            else      s = s >> 1;
        end
        for (int k = 0; k < N; k++) begin
            inj[k] = 1'b0;
            flip_mask[k] = {1'b1, 90'd0};
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check_eq("vec0_is_seed", 128'(exp_vec[0]), 128'(SEED[52:0]));
        rst = 1'b0;

        // clean run with a start pulse mid-run
        do_run(1'b0, 5, -1, 1'b0);

        // y_2[90] flipped for vectors 5 and 9; mismatching garbage outside the tap window
        inj[5] = 1'b1;
        inj[9] = 1'b1;
        do_run(1'b1, -1, -1, 1'b0);
        do_run(1'b1, -1, -1, 1'b1);

        // reset mid-run, then a full rerun
        do_run(1'b1, -1, 7, 1'b0);
        check_reset_values("post_abort");
        do_run(1'b1, -1, -1, 1'b0);

        // random mismatch patterns and flip positions
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) begin
                inj[k] = ($urandom_range(0, 3) == 0);
                m = 91'd1;
                m = m << $urandom_range(0, 90);
                flip_mask[k] = m;
            end
            do_run(1'b1, (r == 1) ? 3 : -1, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
